// File: rtl/regfile_writeback.sv
// Register file with a one-entry writeback holding register, read bypass
// from that entry, and a busy scoreboard for pending destination registers.
module regfile_writeback #(
    parameter int NREG = 16,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_in,
    input  logic          RegWrite_in,
    input  logic          MemtoReg_in,
    input  logic [3:0]    wr_reg,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] mem_data,
    input  logic          issue_en,
    input  logic [3:0]    issue_reg,
    input  logic [3:0]    rs,
    input  logic [3:0]    rt,
    output logic [DW-1:0] read_data1,
    output logic [DW-1:0] read_data2,
    output logic          hazard1,
    output logic          hazard2,
    output logic          wb_valid,
    output logic [15:0]   commit_count
);

    logic [NREG-1:0][DW-1:0] regs;
    logic [3:0]              wb_reg;
    logic [DW-1:0]           wb_data;
    logic [NREG-1:0]         busy;
    logic [NREG-1:0]         busy_nxt;
    logic                    capture;
    logic                    commit;

    assign capture = !stall_in && RegWrite_in;
    assign commit  = !stall_in && wb_valid;

    // Writeback holding register: loads on capture, empties when no write arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
        end else if (!stall_in) begin
            wb_valid <= RegWrite_in;
            if (RegWrite_in) begin
                wb_reg  <= wr_reg;
                wb_data <= MemtoReg_in ? mem_data : alu_result;
            end
        end
    end

    // Commit the held entry into the array; it reads the old wb_* so a
    // same-edge capture never overtakes the older value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs         <= '0;
            commit_count <= '0;
        end else if (commit) begin
            regs[wb_reg] <= wb_data;
            commit_count <= commit_count + 16'd1;
        end
    end

    // Scoreboard next state: clear on capture first so an issue on the
    // same index wins; issue is honoured even while stalled.
    always_comb begin
        busy_nxt = busy;
        if (capture)
            busy_nxt[wr_reg] = 1'b0;
        if (issue_en)
            busy_nxt[issue_reg] = 1'b1;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // Read ports with bypass from the pending writeback entry.
    always_comb begin
        read_data1 = regs[rs];
        read_data2 = regs[rt];
        if (wb_valid && wb_reg == rs)
            read_data1 = wb_data;
        if (wb_valid && wb_reg == rt)
            read_data2 = wb_data;
    end

    assign hazard1 = busy[rs];
    assign hazard2 = busy[rt];

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus a randomized run
// against a queue-based reference model of pending writes.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in, RegWrite_in, MemtoReg_in, issue_en;
    logic [3:0]  wr_reg, issue_reg, rs, rt;
    logic [31:0] alu_result, mem_data;
    logic [31:0] read_data1, read_data2;
    logic        hazard1, hazard2, wb_valid;
    logic [15:0] commit_count;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_writeback #(.NREG(16), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .wr_reg(wr_reg), .alu_result(alu_result), .mem_data(mem_data),
        .issue_en(issue_en), .issue_reg(issue_reg), .rs(rs), .rt(rt),
        .read_data1(read_data1), .read_data2(read_data2),
        .hazard1(hazard1), .hazard2(hazard2), .wb_valid(wb_valid),
        .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    // Reference model: committed values, a FIFO of writes not yet committed,
    // the set of busy registers, and a plain commit counter.
    typedef struct { logic [3:0] r; logic [31:0] d; } wr_t;
    wr_t         pend[$];
    logic [31:0] m_regs[16];
    bit          m_busy[16];
    int          m_cnt;

    function automatic void model_reset();
        pend.delete();
        foreach (m_regs[i]) m_regs[i] = '0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic void model_edge();
        wr_t w;
        if (!stall_in) begin
            if (pend.size() > 0) begin
                w = pend.pop_front();
                m_regs[w.r] = w.d;
                m_cnt++;
            end
            if (RegWrite_in) begin
                w.r = wr_reg;
                w.d = MemtoReg_in ? mem_data : alu_result;
                pend.push_back(w);
                m_busy[wr_reg] = 1'b0;
            end
        end
        if (issue_en) m_busy[issue_reg] = 1'b1;
    endfunction

    function automatic logic [31:0] m_read(logic [3:0] a);
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].r == a) return pend[i].d;
        return m_regs[a];
    endfunction

    task automatic idle();
        stall_in = 0; RegWrite_in = 0; MemtoReg_in = 0; issue_en = 0;
        wr_reg = 0; issue_reg = 0; rs = 0; rt = 0; alu_result = 0; mem_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #3;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        #7;
        rs = 4'd1; rt = 4'd15;
        #1;
        n_checks++; if (read_data1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got %h exp 0", read_data1); end
        n_checks++; if (read_data2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2 got %h exp 0", read_data2); end
        n_checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b%b exp 00", hazard1, hazard2); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wbv got %b exp 0", wb_valid); end
        n_checks++; if (commit_count !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", commit_count); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_basic_write();
        do_reset();
        RegWrite_in = 1; wr_reg = 3; alu_result = 32'h55; mem_data = 32'h99; rs = 3;
        tick();
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL basic_wbv got %b exp 1", wb_valid); end
        n_checks++; if (read_data1 !== 32'h55) begin n_fail++; $display("FAIL basic_bypass got %h exp 55", read_data1); end
        n_checks++; if (commit_count !== 16'd0) begin n_fail++; $display("FAIL basic_cnt0 got %0d exp 0", commit_count); end
        RegWrite_in = 0;
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wbv_clr got %b exp 0", wb_valid); end
        n_checks++; if (read_data1 !== 32'h55) begin n_fail++; $display("FAIL basic_array got %h exp 55", read_data1); end
        n_checks++; if (commit_count !== 16'd1) begin n_fail++; $display("FAIL basic_cnt1 got %0d exp 1", commit_count); end
    endtask

    task automatic test_load_select();
        do_reset();
        RegWrite_in = 1; MemtoReg_in = 1; mem_data = 32'hDEAD; alu_result = 32'h1; wr_reg = 7; rt = 7;
        tick();
        RegWrite_in = 0; MemtoReg_in = 0;
        tick();
        n_checks++; if (read_data2 !== 32'hDEAD) begin n_fail++; $display("FAIL load_sel got %h exp dead", read_data2); end
        n_checks++; if (commit_count !== 16'd1) begin n_fail++; $display("FAIL load_cnt got %0d exp 1", commit_count); end
    endtask

    task automatic test_stall();
        do_reset();
        RegWrite_in = 1; wr_reg = 5; alu_result = 32'h77; rs = 5; rt = 6;
        tick();
        // A write presented during the stall must be ignored.
        stall_in = 1; wr_reg = 6; alu_result = 32'hBB;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL stall_wbv[%0d] got %b exp 1", i, wb_valid); end
            n_checks++; if (commit_count !== 16'd0) begin n_fail++; $display("FAIL stall_cnt[%0d] got %0d exp 0", i, commit_count); end
            n_checks++; if (read_data2 !== 32'h0) begin n_fail++; $display("FAIL stall_reg6[%0d] got %h exp 0", i, read_data2); end
        end
        stall_in = 0; RegWrite_in = 0;
        tick();
        n_checks++; if (commit_count !== 16'd1) begin n_fail++; $display("FAIL stall_release_cnt got %0d exp 1", commit_count); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_wbv got %b exp 0", wb_valid); end
        n_checks++; if (read_data1 !== 32'h77) begin n_fail++; $display("FAIL stall_release_rd got %h exp 77", read_data1); end
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue_en = 1; issue_reg = 9; rs = 9; rt = 8;
        tick();
        n_checks++; if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin n_fail++; $display("FAIL sb_issue got %b%b exp 10", hazard1, hazard2); end
        RegWrite_in = 1; wr_reg = 9;
        tick();
        n_checks++; if (hazard1 !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins got %b exp 1", hazard1); end
        issue_en = 0;
        tick();
        n_checks++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL sb_clear got %b exp 0", hazard1); end
        // Issue acts during a stall; the stalled capture must not clear it.
        RegWrite_in = 0; stall_in = 1; issue_en = 1; issue_reg = 8;
        tick();
        issue_en = 0; RegWrite_in = 1; wr_reg = 8;
        tick();
        n_checks++; if (hazard2 !== 1'b1) begin n_fail++; $display("FAIL sb_stall got %b exp 1", hazard2); end
        stall_in = 0;
        tick();
        n_checks++; if (hazard2 !== 1'b0) begin n_fail++; $display("FAIL sb_unstall got %b exp 0", hazard2); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        RegWrite_in = 1; wr_reg = 2; alu_result = 32'h10; rs = 2; rt = 2;
        tick();
        n_checks++; if (read_data1 !== 32'h10) begin n_fail++; $display("FAIL b2b_first got %h exp 10", read_data1); end
        alu_result = 32'h20;
        tick();
        n_checks++; if (read_data1 !== 32'h20) begin n_fail++; $display("FAIL b2b_bypass got %h exp 20", read_data1); end
        n_checks++; if (commit_count !== 16'd1) begin n_fail++; $display("FAIL b2b_cnt1 got %0d exp 1", commit_count); end
        RegWrite_in = 0;
        tick();
        n_checks++; if (read_data2 !== 32'h20 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_final got %h/%b exp 20/0", read_data2, wb_valid); end
        n_checks++; if (commit_count !== 16'd2) begin n_fail++; $display("FAIL b2b_cnt2 got %0d exp 2", commit_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        RegWrite_in = 1; wr_reg = 4; alu_result = 32'h44; issue_en = 1; issue_reg = 4; rs = 4; rt = 6;
        tick();
        RegWrite_in = 0; issue_reg = 6;
        tick();
        RegWrite_in = 1; wr_reg = 4; alu_result = 32'h45; issue_en = 0;
        tick();
        idle(); rs = 4; rt = 6;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        n_checks++; if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin n_fail++; $display("FAIL rmid_rd got %h/%h exp 0/0", read_data1, read_data2); end
        n_checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin n_fail++; $display("FAIL rmid_hazard got %b%b exp 00", hazard1, hazard2); end
        n_checks++; if (wb_valid !== 1'b0 || commit_count !== 16'd0) begin n_fail++; $display("FAIL rmid_state got %b/%0d exp 0/0", wb_valid, commit_count); end
        #1;
        rst_n = 1;
        tick();
        n_checks++; if (read_data1 !== 32'h0) begin n_fail++; $display("FAIL rmid_dropped got %h exp 0", read_data1); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stall_in    = ($urandom_range(0, 3) == 0);
            RegWrite_in = $urandom_range(0, 1);
            MemtoReg_in = $urandom_range(0, 1);
            wr_reg      = 4'($urandom_range(0, 15));
            alu_result  = $urandom;
            mem_data    = $urandom;
            issue_en    = ($urandom_range(0, 2) == 0);
            issue_reg   = 4'($urandom_range(0, 15));
            rs          = 4'($urandom_range(0, 15));
            rt          = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if (read_data1 !== m_read(rs) || read_data2 !== m_read(rt) ||
                hazard1 !== m_busy[rs] || hazard2 !== m_busy[rt] ||
                wb_valid !== (pend.size() > 0) || commit_count !== m_cnt[15:0]) begin
                n_fail++;
                $display("FAIL rand[%0d] got rd=%h/%h hz=%b%b wbv=%b cnt=%0d exp rd=%h/%h hz=%b%b wbv=%b cnt=%0d",
                         i, read_data1, read_data2, hazard1, hazard2, wb_valid, commit_count,
                         m_read(rs), m_read(rt), m_busy[rs], m_busy[rt], pend.size() > 0, m_cnt[15:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_load_select();
        test_stall();
        test_scoreboard();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL provide parameter NREG, default 16, number of architectural registers, indexed by 4 bits.
REQ-002 SHALL provide parameter DW, default 32, register data width.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide port stall_in  input  1  freezes capture and commit while high.
REQ-006 SHALL provide port RegWrite_in  input  1  the incoming instruction writes a register.
REQ-007 SHALL provide port MemtoReg_in  input  1  1 selects mem_data, 0 selects alu_result.
REQ-008 SHALL provide port wr_reg  input  4  destination register index.
REQ-009 SHALL provide port alu_result  input  DW  ALU result.
REQ-010 SHALL provide port mem_data  input  DW  memory load data.
REQ-011 SHALL provide port issue_en  input  1  decode issued a register-writing instruction.
REQ-012 SHALL provide port issue_reg  input  4  destination register of the issued instruction.
REQ-013 SHALL provide ports rs, rt  input  4 each  read addresses.
REQ-014 SHALL provide ports read_data1, read_data2  output  DW each  read data for rs and rt.
REQ-015 SHALL provide ports hazard1, hazard2  output  1 each  rs or rt has a pending, not yet available write.
REQ-016 SHALL provide port wb_valid  output  1  the writeback holding register holds a pending commit.
REQ-017 SHALL provide port commit_count  output  16  number of register commits, wrapping.

Function
REQ-018 SHALL hold a storage array of NREG x DW registers; all entries SHALL be writable, with no hardwired zero.
REQ-019 SHALL capture a new entry at posedge when stall_in=0 and RegWrite_in=1: wb_valid<=1, wb_reg<=wr_reg, wb_data<=(MemtoReg_in ? mem_data : alu_result).
REQ-020 SHALL, at posedge with stall_in=0 and RegWrite_in=0, set wb_valid<=0.
REQ-021 SHALL commit at posedge when stall_in=0 and wb_valid=1: write wb_data into array[wb_reg] and increment commit_count modulo 2^16.
REQ-022 SHALL commit the old entry and capture the new one in the same edge when both are due (capture-to-array latency exactly 2 edges).
REQ-023 SHALL hold wb_valid, wb_reg, wb_data, the array and commit_count unchanged while stall_in=1.
REQ-024 SHALL drive read_data1 combinationally: wb_data if wb_valid and wb_reg==rs, else array[rs]; read_data2 identically for rt.
REQ-025 SHALL keep a busy vector of NREG bits: issue_en sets busy[issue_reg], and a capture clears busy[wr_reg].
REQ-026 SHALL let set win when the same edge sets and clears the same index.
REQ-027 SHALL let issue_en act while stall_in=1, while clear (capture) SHALL NOT act.
REQ-028 SHALL drive hazard1=busy[rs] and hazard2=busy[rt] combinationally.
REQ-029 SHALL, when a capture targets the same register as the pending commit, commit the older value first, with the bypass returning the newer value immediately.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously clear the array to 0, busy to 0, wb_valid to 0, wb_reg to 0, wb_data to 0 and commit_count to 0.
REQ-031 SHALL drop an uncommitted pending write if reset occurs mid-operation; the write never reaches the array.
REQ-032 SHALL drive outputs after reset: read_data1=read_data2=0, hazard1=hazard2=0, wb_valid=0, commit_count=0.

Verification
REQ-033 SHALL cover basic write: RegWrite_in=1, wr_reg=3, alu_result=0x55, MemtoReg_in=0, one edge -> wb_valid=1 and rs=3 reads 0x55 via bypass; next edge -> array[3]=0x55, commit_count=1.
REQ-034 SHALL cover load select: MemtoReg_in=1, mem_data=0xDEAD, alu_result=0x1, wr_reg=7 -> array[7]=0xDEAD after 2 edges.
REQ-035 SHALL cover stall: capture to reg 5, then stall_in=1 for 3 edges -> wb_valid stays 1, array[5] stays unchanged, commit_count stays constant; release -> commit on the next edge.
REQ-036 SHALL cover scoreboard: issue_en for reg 9 -> hazard1=1 with rs=9; capture wr_reg=9 with issue_en for reg 9 on the same edge -> busy[9] stays 1; a later capture of reg 9 without issue -> hazard1=0.
REQ-037 SHALL cover back-to-back same register: captures of 0x10 then 0x20 to reg 2 on consecutive edges -> bypass reads 0x20, and the array ends at 0x20 with commit_count=2.
REQ-038 SHALL cover reset mid-operation: pending wb entry for reg 4 plus busy bits set, then rst_n pulsed low between edges -> all outputs are 0 immediately and array[4]=0.
